// File: rtl/inst_mem_loader.sv
// Serial boot loader: takes a little-endian length header, that many 32-bit words,
// and an XOR checksum byte, then writes the words to instruction memory and releases the core.
module inst_mem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst,
    output logic          load_err
);

    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;

    state_t      state, nxt;
    logic [15:0] len;
    logic [15:0] wcnt;
    logic [1:0]  bidx;
    logic [23:0] word;
    logic [7:0]  csum;
    logic        acc;
    logic [15:0] hdr_len;

    assign acc     = in_valid && in_ready;
    assign hdr_len = {in_data, len[7:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LEN_LO;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (start) begin
            nxt = LEN_LO;
        end else if (acc) begin
            case (state)
                LEN_LO: nxt = LEN_HI;
                LEN_HI: nxt = (hdr_len == 16'd0 || hdr_len > 16'(DEPTH)) ? ERROR : DATA;
                DATA:   if (bidx == 2'd3 && (wcnt + 16'd1) == len) nxt = CSUM;
                CSUM:   nxt = (in_data == csum) ? DONE : ERROR;
                default: nxt = state;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        core_rst = 1'b0;
        load_err = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA, CSUM: in_ready = !start;
            DONE:                       core_rst = 1'b1;
            ERROR:                      load_err = 1'b1;
            default: ;
        endcase
    end

    // Datapath: header capture, word assembly, checksum and the registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len        <= '0;
            wcnt       <= '0;
            bidx       <= '0;
            word       <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                wcnt <= '0;
                bidx <= '0;
                csum <= '0;
            end else if (acc) begin
                case (state)
                    LEN_LO: len[7:0] <= in_data;
                    LEN_HI: begin
                        len[15:8] <= in_data;
                        wcnt      <= '0;
                        bidx      <= '0;
                        csum      <= '0;
                    end
                    DATA: begin
                        csum <= csum ^ in_data;
                        bidx <= bidx + 2'd1;
                        case (bidx)
                            2'd0: word[7:0]   <= in_data;
                            2'd1: word[15:8]  <= in_data;
                            2'd2: word[23:16] <= in_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= wcnt[AW-1:0];
                                imem_wdata <= {in_data, word};
                                wcnt       <= wcnt + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader: a stream-level model predicts writes and outcome.
module tb_inst_mem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int F_DONE = 0, F_ERR = 1, F_BUSY = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          load_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]         stim[$];
    logic [AW+31:0]     exp_q[$];
    logic               prev_we = 1'b0;

    inst_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (imem_we) begin
            check("we_single_cycle", {63'd0, prev_we}, 64'd0);
            check("we_outside_reset", {63'd0, rst}, 64'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {26'd0, imem_addr, imem_wdata}, 64'd0);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                check("write_addr", {58'd0, imem_addr}, {58'd0, e[AW+31:32]});
                check("write_data", {32'd0, imem_wdata}, {32'd0, e[31:0]});
            end
        end
        prev_we <= imem_we;
    end

    // Reference: parse the byte stream by its framing rules and queue the expected writes.
    task automatic model(output int fin);
        int n, len, base;
        logic [7:0]  cs;
        logic [31:0] w;
        n = stim.size();
        fin = F_BUSY;
        if (n < 2) return;
        len = int'(stim[0]) + 256 * int'(stim[1]);
        if (len == 0 || len > DEPTH) begin fin = F_ERR; return; end
        cs = 8'h00;
        for (int k = 0; k < len; k++) begin
            base = 2 + 4 * k;
            if (base + 3 >= n) return;
            w = {stim[base+3], stim[base+2], stim[base+1], stim[base]};
            cs = cs ^ stim[base] ^ stim[base+1] ^ stim[base+2] ^ stim[base+3];
            exp_q.push_back({k[AW-1:0], w});
        end
        if (n <= 2 + 4 * len) return;
        fin = (stim[2 + 4 * len] == cs) ? F_DONE : F_ERR;
    endtask

    // mode 0: continuous valid, 1: valid toggles every cycle, 2: random gaps
    task automatic drive(input int mode);
        int i = 0, t = 0, cyc = 0;
        while (i < stim.size()) begin
            @(negedge clk);
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            in_data  = stim[i];
            cyc++;
            #1;
            if (in_valid && in_ready) begin
                i++;
                t = 0;
            end else if (++t > 200) begin
                check("byte_accept_timeout", 64'(i), 64'(stim.size()));
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_final(input string tag, input int fin);
        repeat (3) @(negedge clk);
        check({tag, "_writes_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        if (fin == F_DONE) begin
            check({tag, "_core_rst"}, {63'd0, core_rst}, 64'd1);
            check({tag, "_load_err"}, {63'd0, load_err}, 64'd0);
            check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        end else if (fin == F_ERR) begin
            check({tag, "_core_rst"}, {63'd0, core_rst}, 64'd0);
            check({tag, "_load_err"}, {63'd0, load_err}, 64'd1);
            check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        end else begin
            check({tag, "_core_rst"}, {63'd0, core_rst}, 64'd0);
            check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        end
    endtask

    task automatic rearm();
        @(negedge clk);
        start = 1'b1;
        #1 check("in_ready_during_start", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1 check("rearm_core_rst_low", {63'd0, core_rst}, 64'd0);
        check("rearm_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic load_nominal(input logic [7:0] last);
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h40, 8'h00, 8'h93, 8'h02, 8'h60, 8'h00, last};
    endtask

    task automatic load_random(input int len, input bit bad);
        logic [7:0] cs = 8'h00, b;
        stim.delete();
        stim.push_back(len[7:0]);
        stim.push_back(len[15:8]);
        for (int k = 0; k < 4 * len; k++) begin
            b = 8'($urandom);
            cs ^= b;
            stim.push_back(b);
        end
        if (bad) cs ^= 8'($urandom_range(1, 255));
        stim.push_back(cs);
    endtask

    task automatic run(input string tag, input int mode);
        int fin;
        model(fin);
        drive(mode);
        check_final(tag, fin);
    endtask

    initial begin
        #1;
        check("rst_imem_we", {63'd0, imem_we}, 64'd0);
        check("rst_imem_addr", {58'd0, imem_addr}, 64'd0);
        check("rst_imem_wdata", {32'd0, imem_wdata}, 64'd0);
        check("rst_core_rst", {63'd0, core_rst}, 64'd0);
        check("rst_load_err", {63'd0, load_err}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        load_nominal(8'hA7);
        run("nominal", 0);

        rearm();
        load_nominal(8'hA6);
        run("bad_csum", 0);

        rearm();
        stim = '{8'h00, 8'h00};
        run("len_zero", 0);

        rearm();
        stim = '{8'h41, 8'h00};
        run("len_65", 0);

        rearm();
        load_random(64, 1'b0);
        run("len_64", 2);

        rearm();
        load_nominal(8'hA7);
        run("toggle_valid", 1);

        // Abandon a half-assembled word; nothing from it may be written.
        rearm();
        stim = '{8'h02, 8'h00, 8'hDE, 8'hAD};
        drive(0);
        rearm();
        load_nominal(8'hA7);
        run("start_mid_word", 0);

        // Async reset while in DONE, between clock edges.
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_rst_core_rst", {63'd0, core_rst}, 64'd0);
        check("async_rst_imem_we", {63'd0, imem_we}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("after_rst_load_err", {63'd0, load_err}, 64'd0);

        for (int r = 0; r < 6; r++) begin
            load_random($urandom_range(1, 6), ($urandom_range(0, 2) == 0));
            run("random", 2);
            rearm();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64: instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default 6: word-address width, equal to clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: re-arm pulse that restarts loading from the length header.
REQ-006 SHALL have port in_data, input, 8 bits: serial load byte.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: loader accepts a byte.
REQ-009 SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-010 SHALL have port imem_addr, output, AW bits: word address of the write.
REQ-011 SHALL have port imem_wdata, output, 32 bits: instruction word to write.
REQ-012 SHALL have port core_rst, output, 1 bit: active-low reset to the RISC-V core; high only in state DONE.
REQ-013 SHALL have port load_err, output, 1 bit: high in state ERROR.

Function
REQ-014 SHALL accept a byte only in a cycle with in_valid && in_ready at the clk edge.
REQ-015 SHALL drive in_ready = (state in {LEN_LO, LEN_HI, DATA, CSUM}) && !start; this path is combinational.
REQ-016 SHALL implement states LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
REQ-017 SHALL, in LEN_LO, store the accepted byte as len[7:0] and move to LEN_HI.
REQ-018 SHALL, in LEN_HI, store len[15:8], then go to ERROR if len == 0 or len > DEPTH, otherwise go to DATA with word counter = 0, byte index = 0, and checksum = 0.
REQ-019 SHALL, in DATA, assemble bytes little-endian: byte index 0 -> bits [7:0], through byte index 3 -> bits [31:24].
REQ-020 SHALL, on acceptance of byte index 3, pulse imem_we high for exactly the next cycle, with imem_wdata = the assembled word and imem_addr = the word counter; outputs are registered, so latency is 1 cycle from the 4th byte.
REQ-021 SHALL increment the word counter after each written word and move to CSUM when the counter reaches len.
REQ-022 SHALL update checksum = checksum XOR byte for every DATA byte; length and checksum bytes are excluded.
REQ-023 SHALL, in CSUM, compare the accepted byte with checksum: equal -> DONE, unequal -> ERROR.
REQ-024 SHALL hold in DONE and ERROR, ignoring in_valid, until start.
REQ-025 SHALL, when start is high at a clk edge in any state, go to LEN_LO, clear the counter, byte index and checksum, discard any partial word, and drop core_rst low in the same edge if leaving DONE; any byte presented in that cycle is not accepted.
REQ-026 SHALL keep imem_we low in every state except the single cycle after a word completes.
REQ-027 SHALL NOT exceed address DEPTH-1; this is guaranteed by the len check in REQ-018.

Reset
REQ-028 SHALL, on rst low, immediately set state = LEN_LO, imem_we = 0, imem_addr = 0, imem_wdata = 0, core_rst = 0, load_err = 0, and clear len, counter, byte index and checksum.
REQ-029 SHALL, on rst low mid-load, abandon the load; after rst rises, loading restarts at LEN_LO, and no write may occur during reset.

Verification
REQ-030 SHALL cover a nominal load: bytes 02 00 13 05 40 00 93 02 60 00 A7 -> writes addr0 = 0x00400513, then addr1 = 0x00600293, each imem_we lasting 1 cycle; core_rst rises after the A7 byte; load_err = 0.
REQ-031 SHALL cover a bad checksum: the same stream ending with 0xA6 -> both words written; ERROR state, load_err = 1, core_rst = 0, in_ready = 0.
REQ-032 SHALL cover length bounds: header 00 00 -> ERROR with no imem_we; header 41 00 (65 > DEPTH) -> ERROR; header 40 00 with 64 words and a correct checksum -> last write at addr 63, then DONE.
REQ-033 SHALL cover backpressure and gaps: in_valid toggling every cycle during the nominal stream -> identical writes and identical final state.
REQ-034 SHALL cover start mid-word: start after 2 DATA bytes, then a fresh nominal stream -> the partial word is never written, the fresh writes begin at addr 0, and the load ends in DONE.
REQ-035 SHALL cover async reset in DONE: rst low between clock edges -> core_rst = 0 immediately; after rst rises, state = LEN_LO and in_ready = 1.
